// File: rtl/fpmult_arbiter.sv
// Two-requester round-robin front end for one shared fixed-latency FP multiplier.
// Credits bound in-flight work so each requester's in-order result FIFO cannot overflow.
module fpmult_arbiter #(
  parameter int LATENCY    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        mul_in_valid,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_res,
  output logic        res0_valid,
  input  logic        res0_ready,
  output logic [31:0] res0_data,
  output logic        res1_valid,
  input  logic        res1_ready,
  output logic [31:0] res1_data
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DepthVal = (PW + 1)'(FIFO_DEPTH);
  localparam logic [PW:0] PtrOne   = (PW + 1)'(1);

  typedef enum logic {
    PRIO0,
    PRIO1
  } prio_t;

  prio_t prioQ, prioD;

  logic [1:0]  reqValid;
  logic [31:0] reqA [2];
  logic [31:0] reqB [2];
  logic [1:0]  elig;
  logic [1:0]  grant;
  logic        issue;
  logic        issueId;

  logic        mulValidQ;
  logic        mulIdQ;
  logic [31:0] mulAQ;
  logic [31:0] mulBQ;

  logic [LATENCY-1:0] tagValid;
  logic [LATENCY-1:0] tagId;
  logic        pushEn;
  logic        pushId;

  logic [PW:0] used  [2];
  logic [PW:0] wrPtr [2];
  logic [PW:0] rdPtr [2];
  logic [31:0] mem   [2][FIFO_DEPTH];
  logic [1:0]  resReady;
  logic [1:0]  resValid;
  logic [31:0] resData [2];
  logic [1:0]  popReq;

  assign reqValid = {req1_valid, req0_valid};
  assign reqA[0]  = req0_a;
  assign reqA[1]  = req1_a;
  assign reqB[0]  = req0_b;
  assign reqB[1]  = req1_b;
  assign resReady = {res1_ready, res0_ready};

  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      elig[i] = !rst && reqValid[i] && (used[i] < DepthVal);
    end
  end

  // Priority points at the requester not granted at the last issue.
  always_comb begin
    prioD = prioQ;
    grant = elig;
    if (elig == 2'b11) begin
      grant = (prioQ == PRIO0) ? 2'b01 : 2'b10;
    end
    if (grant[0]) begin
      prioD = PRIO1;
    end else if (grant[1]) begin
      prioD = PRIO0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prioQ <= PRIO0;
    end else begin
      prioQ <= prioD;
    end
  end

  assign issue      = |grant;
  assign issueId    = grant[1];
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      mulValidQ <= 1'b0;
      mulIdQ    <= 1'b0;
      mulAQ     <= '0;
      mulBQ     <= '0;
    end else begin
      mulValidQ <= issue;
      if (issue) begin
        mulIdQ <= issueId;
        mulAQ  <= reqA[issueId];
        mulBQ  <= reqB[issueId];
      end
    end
  end

  assign mul_in_valid = !rst && mulValidQ;
  assign mul_a        = rst ? '0 : mulAQ;
  assign mul_b        = rst ? '0 : mulBQ;

  // Tags enter alongside the registered issue so the last stage lines up with mul_res.
  always_ff @(posedge clk) begin
    if (rst) begin
      tagValid <= '0;
      tagId    <= '0;
    end else begin
      tagValid[0] <= mulValidQ;
      tagId[0]    <= mulIdQ;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        tagValid[i] <= tagValid[i-1];
        tagId[i]    <= tagId[i-1];
      end
    end
  end

  assign pushEn = tagValid[LATENCY-1];
  assign pushId = tagId[LATENCY-1];

  always_comb begin
    resValid = '0;
    popReq   = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      resValid[i] = !rst && (wrPtr[i] != rdPtr[i]);
      resData[i]  = resValid[i] ? mem[i][rdPtr[i][PW-1:0]] : '0;
      popReq[i]   = resValid[i] && resReady[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        wrPtr[i] <= '0;
        rdPtr[i] <= '0;
        used[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (pushEn && (pushId == i[0])) begin
          wrPtr[i] <= wrPtr[i] + PtrOne;
        end
        if (popReq[i]) begin
          rdPtr[i] <= rdPtr[i] + PtrOne;
        end
        if (grant[i] && !popReq[i]) begin
          used[i] <= used[i] + PtrOne;
        end else if (!grant[i] && popReq[i]) begin
          used[i] <= used[i] - PtrOne;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pushEn) begin
      mem[pushId][wrPtr[pushId][PW-1:0]] <= mul_res;
    end
  end

  assign res0_valid = resValid[0];
  assign res1_valid = resValid[1];
  assign res0_data  = resData[0];
  assign res1_data  = resData[1];

endmodule
